// File: rtl/rv32i_operand_fetch.sv
// RV32I operand fetch: sequences register file reads around the one-clock
// BRAM latency, forwards in-flight writebacks and hands operands to execute.
module rv32i_operand_fetch #(
  parameter int XLEN     = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [REG_BITS-1:0] req_rs1_i,
  input  logic [REG_BITS-1:0] req_rs2_i,
  input  logic                wb_valid_i,
  output logic                wb_ready_o,
  input  logic [REG_BITS-1:0] wb_rd_i,
  input  logic [XLEN-1:0]     wb_data_i,
  output logic [REG_BITS-1:0] rf_rs1_addr_o,
  output logic [REG_BITS-1:0] rf_rs2_addr_o,
  output logic [REG_BITS-1:0] rf_rd_addr_o,
  output logic [XLEN-1:0]     rf_data_o,
  output logic                rf_write_o,
  input  logic [XLEN-1:0]     rf_rs1_i,
  input  logic [XLEN-1:0]     rf_rs2_i,
  output logic                op_valid_o,
  input  logic                op_ready_i,
  output logic [XLEN-1:0]     op_rs1_o,
  output logic [XLEN-1:0]     op_rs2_o
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    VALID
  } state_t;

  state_t state_q;

  logic            fwd1_q;
  logic            fwd2_q;
  logic [XLEN-1:0] fwd1_data_q;
  logic [XLEN-1:0] fwd2_data_q;

  logic            commit;
  logic            hit1;
  logic            hit2;
  logic            req_rdy;
  logic            accept;
  logic [XLEN-1:0] cap1;
  logic [XLEN-1:0] cap2;

  assign wb_ready_o   = rst_ni;
  assign rf_rd_addr_o = wb_rd_i;
  assign rf_data_o    = wb_data_i;
  assign rf_write_o   = wb_valid_i && (wb_rd_i != '0) && rst_ni;
  assign commit       = rf_write_o;

  assign hit1 = commit && (wb_rd_i == rf_rs1_addr_o);
  assign hit2 = commit && (wb_rd_i == rf_rs2_addr_o);

  always_comb begin
    req_rdy = 1'b0;
    unique case (state_q)
      IDLE:    req_rdy = 1'b1;
      VALID:   req_rdy = op_ready_i;
      default: req_rdy = 1'b0;
    endcase
  end

  assign req_ready_o = rst_ni && req_rdy;
  assign accept      = req_valid_i && req_ready_o;

  // x0 wins over everything, then the newest data source
  always_comb begin
    cap1 = rf_rs1_i;
    if (rf_rs1_addr_o == '0) cap1 = '0;
    else if (hit1)           cap1 = wb_data_i;
    else if (fwd1_q)         cap1 = fwd1_data_q;
  end

  always_comb begin
    cap2 = rf_rs2_i;
    if (rf_rs2_addr_o == '0) cap2 = '0;
    else if (hit2)           cap2 = wb_data_i;
    else if (fwd2_q)         cap2 = fwd2_data_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      op_valid_o    <= 1'b0;
      op_rs1_o      <= '0;
      op_rs2_o      <= '0;
      rf_rs1_addr_o <= '0;
      rf_rs2_addr_o <= '0;
      fwd1_q        <= 1'b0;
      fwd2_q        <= 1'b0;
      fwd1_data_q   <= '0;
      fwd2_data_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            rf_rs1_addr_o <= req_rs1_i;
            rf_rs2_addr_o <= req_rs2_i;
            state_q       <= ADDR;
          end
        end
        ADDR: begin
          // the BRAM samples now and misses this commit
          if (hit1) begin
            fwd1_q      <= 1'b1;
            fwd1_data_q <= wb_data_i;
          end
          if (hit2) begin
            fwd2_q      <= 1'b1;
            fwd2_data_q <= wb_data_i;
          end
          state_q <= DATA;
        end
        DATA: begin
          op_rs1_o   <= cap1;
          op_rs2_o   <= cap2;
          fwd1_q     <= 1'b0;
          fwd2_q     <= 1'b0;
          op_valid_o <= 1'b1;
          state_q    <= VALID;
        end
        VALID: begin
          if (hit1) op_rs1_o <= wb_data_i;
          if (hit2) op_rs2_o <= wb_data_i;
          if (op_ready_i) begin
            op_valid_o <= 1'b0;
            if (req_valid_i) begin
              rf_rs1_addr_o <= req_rs1_i;
              rf_rs2_addr_o <= req_rs2_i;
              state_q       <= ADDR;
            end else begin
              state_q <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/rv32i_operand_fetch.md
Name: rv32i_operand_fetch

Overview:
Initiator-side sequencer for the RV32I register file: it drives the file's read addresses and write strobe. It accepts decoded source-register requests and waits out the register file's one-clock BRAM read latency. It forwards writebacks that commit while a read is in flight, forces x0 to zero, and presents both operands to execute with a valid/ready handshake. It also routes execute-stage writebacks into the register file and blocks writes to x0.

Parameters:
XLEN, 32, data width of registers and operands
REG_BITS, 5, register address width

Ports:
clk_i  input  1  clock; all state changes on rising edge
rst_ni  input  1  synchronous reset, active low
req_valid_i  input  1  decode presents rs1/rs2 request
req_ready_o  output  1  request accepted on valid&&ready
req_rs1_i  input  REG_BITS  source register 1 index
req_rs2_i  input  REG_BITS  source register 2 index
wb_valid_i  input  1  writeback commit request
wb_ready_o  output  1  writeback accepted
wb_rd_i  input  REG_BITS  destination register
wb_data_i  input  XLEN  writeback data
rf_rs1_addr_o  output  REG_BITS  register file read address 1, registered
rf_rs2_addr_o  output  REG_BITS  register file read address 2, registered
rf_rd_addr_o  output  REG_BITS  register file write address
rf_data_o  output  XLEN  register file write data
rf_write_o  output  1  register file write strobe
rf_rs1_i  input  XLEN  register file read data 1, valid one clock after address sampled
rf_rs2_i  input  XLEN  register file read data 2
op_valid_o  output  1  operands valid
op_ready_i  input  1  execute consumes operands
op_rs1_o  output  XLEN  operand 1, registered
op_rs2_o  output  XLEN  operand 2, registered

Behaviour:
- Reset (rst_ni low at an edge):
  - state=IDLE; op_valid_o=0; op_rs1_o/op_rs2_o=0; rf_rs*_addr_o=0; forward flags cleared.
  - req_ready_o and wb_ready_o are 0 while rst_ni is low.
  - Reset overrides any in-flight operation, including mid-read.
- Writeback path:
  - wb_ready_o=1 whenever out of reset.
  - rf_rd_addr_o=wb_rd_i and rf_data_o=wb_data_i, both combinational.
  - rf_write_o = wb_valid_i && wb_rd_i!=0 && rst_ni.
  - A "commit" is rf_write_o high at a rising edge.
- FSM states: IDLE, ADDR, DATA, VALID.
  - IDLE: req_ready_o=1. On accept, latch rs1/rs2 into the address registers and go to ADDR.
  - ADDR: the register file samples the stable addresses at this edge. Go to DATA.
  - DATA: capture operands into op_rs*_o. Go to VALID, with op_valid_o=1 from the next cycle.
  - VALID: op_valid_o=1 and operands held stable. On op_ready_i: if req_valid_i is also high, accept the new request in the same cycle (req_ready_o = op_ready_i in VALID) and go to ADDR; otherwise go to IDLE.
- Latency: accept edge E0, operands captured at E2, op_valid_o visible after E2. Sustained throughput is one request per 3 cycles.
- Forwarding, per operand n:
  - A commit at the accept edge E0 is visible to the read sampled at E1, so no forward is needed.
  - A commit in ADDR whose rd equals address n sets fwd_n and stores the data. A later matching commit overwrites it (latest wins).
  - Capture in DATA uses this priority: matching same-cycle commit, then fwd_n data, then rf_rsn_i.
  - In VALID, a matching commit updates the held op_rsn_o. Operands therefore reflect every commit before the consume edge.
  - fwd_n is cleared on capture.
- x0: if the latched address is 0, the operand is 0, regardless of register file data or forwarding.
- rs1==rs2: both operands receive identical values, including forwarded ones.
- A commit to rd=0 is never performed, since rf_write_o stays 0. The write is still acknowledged by wb_ready_o.

Test Plan:
- Write x5=0x12345678. Request rs1=5, rs2=0 → op_valid_o after 2 cycles; op_rs1_o=0x12345678, op_rs2_o=0.
- Accept rs1=rs2=3 with x3=0x11111111, then commit x3=0xDEADBEEF in ADDR → op_rs1_o=op_rs2_o=0xDEADBEEF.
- Accept rs1=7 with x7=0x1, commit x7=0x2 in ADDR, then x7=0x3 in DATA → op_rs1_o=0x3.
- Writeback rd=0, data 0xFFFFFFFF → rf_write_o stays 0, wb_ready_o=1; a later read of x0 returns 0.
- Hold op_ready_i low for 3 cycles in VALID (rs2=9) and commit x9=0xA5A5A5A5 → op_rs2_o updates to 0xA5A5A5A5. Then raise op_ready_i with req_valid_i high → new request accepted the same cycle and next state is ADDR.
- Pull rst_ni low during DATA → next cycle op_valid_o=0 and state is IDLE. After release, req_ready_o=1 and a fresh request completes normally.
